// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the core data port and the memory write bus, with load forwarding.
// Optional: define WB_COALESCE_EN to merge a store into the youngest entry when addresses match.
module dmem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        wb_empty,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  output logic [31:0] bus_raddr,
  input  logic [31:0] bus_rdata
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [29:0]      cpu_word;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             coal;
  logic [PTR_W-1:0] fwd_idx;
  logic             addr_lsb_unused;

  assign cpu_word        = cpu_addr[31:2];
  assign addr_lsb_unused = ^cpu_addr[1:0];
  assign full            = (count == CNT_W'(DEPTH));
  assign empty           = (count == '0);

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] last;
  assign last = tail - PTR_W'(1);
  // count>=2 keeps the head (currently on the bus) out of the merge path
  assign coal = cpu_we && (count >= CNT_W'(2)) && (addr_q[last] == cpu_word);
`else
  assign coal = 1'b0;
`endif

  assign stall     = cpu_we & full & ~coal;
  assign push      = cpu_we & ~full & ~coal;
  assign pop       = ~empty & bus_ready;

  assign bus_valid = ~empty;
  assign bus_addr  = {addr_q[head], 2'b00};
  assign bus_wdata = data_q[head];
  assign wb_empty  = empty;
  assign bus_raddr = {cpu_word, 2'b00};

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    read_data = bus_rdata;
    fwd_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_q[fwd_idx] == cpu_word))
        read_data = data_q[fwd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= cpu_word;
      data_q[tail] <= cpu_wdata;
    end
`ifdef WB_COALESCE_EN
    if (coal)
      data_q[last] <= cpu_wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + PTR_W'(1);
      if (pop)
        head <= head + PTR_W'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_dmem_write_buffer.sv
// Self-checking bench for dmem_write_buffer against a queue-based reference model.
module tb_dmem_write_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [31:0] read_data;
  logic        stall;
  logic        wb_empty;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_raddr;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t        mq[$];
  logic [63:0] dut_log[$];

  dmem_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .read_data(read_data), .stall(stall), .wb_empty(wb_empty), .bus_valid(bus_valid),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_raddr(bus_raddr), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [31:0] rdata);
    model_read = rdata;
    foreach (mq[i])
      if (mq[i].a == addr[31:2]) model_read = mq[i].d;
  endfunction

  function automatic bit model_hit();
    model_hit = 1'b0;
`ifdef WB_COALESCE_EN
    if (cpu_we && mq.size() >= 2 && mq[mq.size()-1].a == cpu_addr[31:2]) model_hit = 1'b1;
`endif
  endfunction

  // One clock: log DUT handshakes, advance the model with the inputs seen at the edge.
  task automatic tick();
    bit hit;
    bit do_pop;
    bit do_push;
    if (bus_valid && bus_ready) dut_log.push_back({bus_addr, bus_wdata});
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      hit     = model_hit();
      do_pop  = (mq.size() > 0) && bus_ready;
      do_push = cpu_we && !hit && (mq.size() < DEPTH);
      if (hit) mq[mq.size()-1].d = cpu_wdata;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{cpu_addr[31:2], cpu_wdata});
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_we = 1'b0; bus_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus_valid); end
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", wb_empty); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
  endtask

  task automatic test_basic();
    do_reset();
    store(32'h100, 32'hDEADBEEF);
    cpu_addr = 32'h103; bus_rdata = 32'h0;
    #1;
    checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus_valid); end
    checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL basic_addr: got %h expected 00000100", bus_addr); end
    checks++; if (bus_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_wdata: got %h expected deadbeef", bus_wdata); end
    checks++; if (wb_empty !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b expected 0", wb_empty); end
    checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_fwd: got %h expected deadbeef", read_data); end
    checks++; if (bus_raddr !== 32'h100) begin errors++; $display("FAIL basic_raddr: got %h expected 00000100", bus_raddr); end
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    #1;
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL basic_drained: got %b expected 1", wb_empty); end
  endtask

  task automatic test_full_stall();
    logic [31:0] exp_addr [4];
    exp_addr = '{32'h4, 32'h8, 32'hC, 32'h10};
    do_reset();
    for (int i = 0; i < 4; i++) store(32'(i * 4), 32'hA0 + 32'(i));
    cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hA4;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b expected 1", stall); end
    checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", dut.count); end
    bus_ready = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_pop_stall: got %b expected 1", stall); end
    tick();
    bus_ready = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_release: got %b expected 0", stall); end
    checks++; if (dut.count !== 3'd3) begin errors++; $display("FAIL full_count3: got %0d expected 3", dut.count); end
    tick();
    cpu_we = 1'b0;
    #1;
    checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL full_accept: got %0d expected 4", dut.count); end
    bus_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus_valid !== 1'b1 || bus_addr !== exp_addr[k]) begin
        errors++; $display("FAIL drain_order%0d: got v=%b a=%h expected v=1 a=%h", k, bus_valid, bus_addr, exp_addr[k]);
      end
      tick();
    end
    bus_ready = 1'b0;
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", wb_empty); end
  endtask

  task automatic test_forward();
    logic [2:0] exp_cnt;
`ifdef WB_COALESCE_EN
    exp_cnt = 3'd2;
`else
    exp_cnt = 3'd3;
`endif
    do_reset();
    store(32'h300, 32'h1);
    store(32'h200, 32'hA);
    store(32'h200, 32'hB);
    cpu_addr = 32'h200; bus_rdata = $urandom;
    #1;
    checks++; if (read_data !== 32'hB) begin errors++; $display("FAIL fwd_youngest: got %h expected 0000000b", read_data); end
    checks++; if (dut.count !== exp_cnt) begin errors++; $display("FAIL fwd_count: got %0d expected %0d", dut.count, exp_cnt); end
    cpu_addr = 32'h302;
    #1;
    checks++; if (read_data !== 32'h1) begin errors++; $display("FAIL fwd_head: got %h expected 00000001", read_data); end
    cpu_addr = 32'h400; bus_rdata = 32'h1234;
    #1;
    checks++; if (read_data !== 32'h1234) begin errors++; $display("FAIL fwd_miss: got %h expected 00001234", read_data); end
    cpu_we = 1'b1; cpu_addr = 32'h500; cpu_wdata = 32'h77;
    #1;
    checks++; if (read_data !== 32'h1234) begin errors++; $display("FAIL fwd_same_cycle: got %h expected 00001234", read_data); end
    tick();
    cpu_we = 1'b0;
    #1;
    checks++; if (read_data !== 32'h77) begin errors++; $display("FAIL fwd_next_cycle: got %h expected 00000077", read_data); end
  endtask

  task automatic test_random();
    logic [31:0] wdat [16];
    logic [31:0] prev_a;
    logic [31:0] prev_d;
    logic [31:0] exp_rd;
    bit          prev_hold;
    bit          exp_stall;
    int          n;
    int          cyc;
    do_reset();
    dut_log.delete();
    foreach (wdat[i]) wdat[i] = $urandom;
    n = 0; cyc = 0; prev_hold = 1'b0; prev_a = '0; prev_d = '0;
    while ((n < 16 || mq.size() > 0) && cyc < 400) begin
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      if (n < 16) begin
        cpu_we = 1'b1; cpu_addr = 32'h1000 + 32'(n * 4); cpu_wdata = wdat[n];
      end else begin
        cpu_we = 1'b0; cpu_addr = 32'h1000 + 32'($urandom_range(0, 15) * 4);
      end
      #1;
      exp_stall = cpu_we && (mq.size() == DEPTH) && !model_hit();
      exp_rd    = model_read(cpu_addr, bus_rdata);
      checks++; if (bus_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", cyc, bus_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++;
        if (bus_addr !== {mq[0].a, 2'b00} || bus_wdata !== mq[0].d) begin
          errors++; $display("FAIL rnd_head c%0d: got %h/%h expected %h/%h", cyc, bus_addr, bus_wdata, {mq[0].a, 2'b00}, mq[0].d);
        end
      end
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall c%0d: got %b expected %b", cyc, stall, exp_stall); end
      checks++; if (read_data !== exp_rd) begin errors++; $display("FAIL rnd_read c%0d: got %h expected %h", cyc, read_data, exp_rd); end
      if (prev_hold) begin
        checks++;
        if (bus_valid !== 1'b1 || bus_addr !== prev_a || bus_wdata !== prev_d) begin
          errors++; $display("FAIL rnd_stable c%0d: got %b %h/%h expected 1 %h/%h", cyc, bus_valid, bus_addr, bus_wdata, prev_a, prev_d);
        end
      end
      prev_hold = bus_valid && !bus_ready;
      prev_a = bus_addr; prev_d = bus_wdata;
      if (cpu_we && !exp_stall) n++;
      tick();
      cyc++;
    end
    cpu_we = 1'b0; bus_ready = 1'b0;
    checks++; if (cyc >= 400) begin errors++; $display("FAIL rnd_timeout: got %0d cycles expected under 400", cyc); end
    checks++; if (dut_log.size() != 16) begin errors++; $display("FAIL rnd_count: got %0d writes expected 16", dut_log.size()); end
    for (int i = 0; i < 16 && i < dut_log.size(); i++) begin
      checks++;
      if (dut_log[i] !== {32'h1000 + 32'(i * 4), wdat[i]}) begin
        errors++; $display("FAIL rnd_mem%0d: got %h expected %h", i, dut_log[i], {32'h1000 + 32'(i * 4), wdat[i]});
      end
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    store(32'h100, 32'h11);
    store(32'h104, 32'h22);
    store(32'h108, 32'h33);
    rst = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10C; cpu_wdata = 32'h44; bus_ready = 1'b1;
    tick();
    rst = 1'b0; cpu_we = 1'b0; bus_ready = 1'b0;
    cpu_addr = 32'h100; bus_rdata = 32'h55AA55AA;
    #1;
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rstp_valid: got %b expected 0", bus_valid); end
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL rstp_empty: got %b expected 1", wb_empty); end
    checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL rstp_count: got %0d expected 0", dut.count); end
    checks++; if (read_data !== 32'h55AA55AA) begin errors++; $display("FAIL rstp_read: got %h expected 55aa55aa", read_data); end
  endtask

  task automatic test_push_pop();
    do_reset();
    store(32'h40, 32'h1);
    store(32'h44, 32'h2);
    cpu_we = 1'b1; cpu_addr = 32'h48; cpu_wdata = 32'h3; bus_ready = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pp_stall: got %b expected 0", stall); end
    tick();
    cpu_we = 1'b0; bus_ready = 1'b0;
    #1;
    checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL pp_count: got %0d expected 2", dut.count); end
    checks++; if (dut.head !== 2'd1) begin errors++; $display("FAIL pp_head: got %0d expected 1", dut.head); end
    checks++; if (dut.tail !== 2'd3) begin errors++; $display("FAIL pp_tail: got %0d expected 3", dut.tail); end
    checks++; if (bus_addr !== 32'h44) begin errors++; $display("FAIL pp_bus: got %h expected 00000044", bus_addr); end
  endtask

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
    #1;
    test_reset();
    test_basic();
    test_full_stall();
    test_forward();
    test_random();
    test_reset_pending();
    test_push_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Posted-write buffer between the single-cycle core's data-memory port and the external data-memory bus.
- Accepts core stores in one cycle and queues them in a DEPTH-entry FIFO.
- Drains entries in order over a valid/ready write channel.
- Loads are served combinationally from the bus read port, with forwarding from queued stores, so the core's single-cycle timing is preserved.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, >=2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
cpu_addr  input  32  core data address (core's datamem_rd); byte address, bits [1:0] ignored
cpu_wdata  input  32  core store data (core's datamem_wr)
cpu_we  input  1  core store strobe (core's memwr_sgn)
read_data  output  32  load data to core, combinational
stall  output  1  store not accepted this cycle; core must hold
wb_empty  output  1  FIFO empty (fence/drain indication)
bus_valid  output  1  write request valid
bus_addr  output  32  write word address, [1:0]=00
bus_wdata  output  32  write data
bus_ready  input  1  memory accepts write at rising edge when bus_valid=1
bus_raddr  output  32  combinational read address = {cpu_addr[31:2],2'b00}
bus_rdata  input  32  combinational read data from memory

Behaviour:
- Storage:
  - Entry = {word address [31:2], data [31:0]}.
  - Registered head pointer, tail pointer and count; pointers wrap modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Reset (sync, rst=1 at edge):
  - count, head and tail go to 0; all pending entries are discarded.
  - Following cycle: bus_valid=0, wb_empty=1, stall=0.
  - Reset overrides any push or pop in the same cycle.
- Push:
  - cpu_we=1 and !full at the edge: write cpu_addr/cpu_wdata at tail, tail+1, count+1.
  - Latency: the entry is visible on the bus the next cycle if it becomes the head.
- Stall:
  - stall = cpu_we & full, combinational from the registered count.
  - A stalled store is not written. It is accepted on the first edge where full=0 and cpu_we is still held.
- Pop:
  - bus_valid = !empty; bus_addr/bus_wdata = head entry.
  - On bus_valid & bus_ready at the edge: head+1, count-1.
  - bus_addr/bus_wdata are stable while bus_valid=1 and bus_ready=0.
  - bus_valid never drops without a handshake, except on reset.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- When full, a same-cycle pop does not admit the store: stall=1 that cycle; the store is accepted the next cycle.
- Ordering: bus writes leave in exact acceptance order; no reordering or dropping.
- Load forwarding (read_data, combinational):
  - Compare cpu_addr[31:2] against every valid entry.
  - If any match, return the data of the youngest matching entry; otherwise return bus_rdata.
  - The head entry being popped this cycle still participates.
  - A store accepted in the current cycle is not visible to read_data until the next cycle.
- wb_empty = empty, registered-state derived.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: a store whose word address equals the youngest entry's address, with count>=2, overwrites that entry's data in place.
  - count is unchanged and no stall occurs, even when full.
  - The head entry is never coalesced (count==1 still allocates), to keep bus payload stable.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset, bus_ready=0, store 0x100<=0xDEADBEEF -> next cycle bus_valid=1, bus_addr=0x100, bus_wdata=0xDEADBEEF, wb_empty=0; load 0x100 with bus_rdata=0 -> read_data=0xDEADBEEF.
- Four stores to 0x0,0x4,0x8,0xC with ready=0, then fifth store to 0x10 -> stall=1, count=4; one ready pulse -> stall=1 that cycle, next cycle stall=0 and 0x10 accepted; drain shows 0x4,0x8,0xC,0x10 in order.
- Stores 0x200<=0xA then 0x200<=0xB behind head 0x300 (ready=0) -> load 0x200 returns 0xB; without WB_COALESCE_EN count=3, with it count=2.
- Random bus_ready toggling across 16 stores -> bus_addr/bus_wdata never change while valid&!ready; memory model matches the store sequence exactly.
- Three pending entries, rst=1 for one cycle -> next cycle bus_valid=0, wb_empty=1; load 0x100 returns bus_rdata (0x55AA55AA).
- Push and pop in the same cycle with count=2 -> count stays 2, head/tail both advance, no stall.
